// File: rtl/addsub_pkg.sv
// Shared types and sizing helpers for the digit-serial adder/subtractor.
package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int N_DEF = 8;
   localparam int D_DEF = 2;

   // Digit counter width: enough to count N/D digits, never narrower than one bit.
   function automatic int cnt_w(input int n, input int d);
      int w;
      w = $clog2(n / d);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/addsub_serial_if.sv
// Start/done request bus of the serial adder/subtractor, plus a state debug tap.
// Handshake: start is sampled only while the unit is idle (busy=0); A, B and M are
// captured on that same edge. busy stays high until done has pulsed for exactly one
// cycle, which is the cycle in which S/Cout/V/Z first show the new result.
interface addsub_serial_if
   import addsub_pkg::*;
#(
   parameter int N = N_DEF
);
   logic         start;
   logic         M;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic         busy;
   logic         done;
   logic [N-1:0] S;
   logic         Cout;
   logic         V;
   logic         Z;
   state_t       state;

   modport master (
      output start, M, A, B,
      input  busy, done, S, Cout, V, Z, state
   );

   modport slave (
      input  start, M, A, B,
      output busy, done, S, Cout, V, Z, state
   );
endinterface

// File: rtl/addsub_digit.sv
// Combinational D-bit ripple adder; also exposes the carry into its top bit so the
// caller can form signed overflow on the final digit.
module addsub_digit #(
   parameter int D = 2
) (
   input  logic [D-1:0] a,
   input  logic [D-1:0] b,
   input  logic         cin,
   output logic [D-1:0] s,
   output logic         cout,
   output logic         c_msb
);
   logic [D:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < D; i++) begin : g_fa
      full_adder u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (c[i]),
         .s    (s[i]),
         .cout (c[i+1])
      );
   end

   assign cout  = c[D];
   assign c_msb = c[D-1];
endmodule

// File: rtl/full_adder.sv
// One-bit full adder, the building block of the digit adder.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/addsub_serial.sv
// Digit-serial two's-complement adder/subtractor: D bits per cycle over N/D cycles.
// Define ADDSUB_SAT_EN to saturate S to signed max/min on overflow.
module addsub_serial
   import addsub_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int D = D_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   addsub_serial_if.slave  bus
);
   localparam int K  = N / D;
   localparam int CW = cnt_w(N, D);
   localparam logic [CW-1:0] LAST = CW'(K - 1);

   if (N < 2 || D < 1 || D > N || (N % D) != 0) begin : g_bad_params
      $error("addsub_serial: need N >= 2, 1 <= D <= N and N divisible by D");
   end

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [N-1:0]    op_a;
   logic [N-1:0]    op_b;
   logic [N-1:0]    sum_sr;
   logic            carry;

   logic [D-1:0]    d_sum;
   logic            d_cout;
   logic            d_cmsb;
   logic [N-1:0]    sum_next;
   logic [N-1:0]    op_a_next;
   logic [N-1:0]    op_b_next;
   logic [N-1:0]    s_final;
   logic            v_next;

   addsub_digit #(.D(D)) u_digit (
      .a     (op_a[D-1:0]),
      .b     (op_b[D-1:0]),
      .cin   (carry),
      .s     (d_sum),
      .cout  (d_cout),
      .c_msb (d_cmsb)
   );

   // New digits enter at the top so after K shifts the sum is right-aligned.
   if (D == N) begin : g_single
      assign sum_next  = d_sum;
      assign op_a_next = '0;
      assign op_b_next = '0;
   end else begin : g_multi
      assign sum_next  = {d_sum, sum_sr[N-1:D]};
      assign op_a_next = {{D{1'b0}}, op_a[N-1:D]};
      assign op_b_next = {{D{1'b0}}, op_b[N-1:D]};
   end

   // Only meaningful on the last digit, where d_cmsb is the carry into bit N-1.
   assign v_next = d_cmsb ^ d_cout;

`ifdef ADDSUB_SAT_EN
   logic a_sign;

   // On overflow both effective operands share A's sign, so it gives the true sign.
   always_comb begin
      s_final = sum_next;
      if (v_next) begin
         s_final = a_sign ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sign <= 1'b0;
      end else if (state == IDLE && bus.start) begin
         a_sign <= bus.A[N-1];
      end
   end
`else
   assign s_final = sum_next;
`endif

   assign bus.state = state;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.S    <= '0;
         bus.Cout <= 1'b0;
         bus.V    <= 1'b0;
         bus.Z    <= 1'b0;
         cnt      <= '0;
         op_a     <= '0;
         op_b     <= '0;
         sum_sr   <= '0;
         carry    <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  // Subtraction is A + ~B + 1: invert B and seed the carry with M.
                  op_a     <= bus.A;
                  op_b     <= bus.B ^ {N{bus.M}};
                  carry    <= bus.M;
                  cnt      <= '0;
                  bus.busy <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               op_a   <= op_a_next;
               op_b   <= op_b_next;
               sum_sr <= sum_next;
               carry  <= d_cout;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST) begin
                  bus.S    <= s_final;
                  bus.Cout <= d_cout;
                  bus.V    <= v_next;
                  bus.Z    <= (s_final == '0);
                  bus.done <= 1'b1;
                  state    <= DONE;
               end
            end
            DONE: begin
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial (N=8, D=2): vector table, handshake corner
// sequences and randomized operations against an integer-arithmetic reference model.
module tb_addsub_serial;
   import addsub_pkg::*;

   localparam int N = 8;
   localparam int D = 2;
   localparam int K = N / D;
   localparam int W = N + 3;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   addsub_serial_if #(.N(N)) bus ();

   addsub_serial #(.N(N), .D(D)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int           n_tests = 0;
   int           n_fail  = 0;
   logic [W-1:0] exp_q[$];
   logic [N-1:0] last_s;

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic         m;
      logic [N-1:0] s;
      logic         cout;
      logic         v;
      logic         z;
   } vec_t;

   vec_t tbl[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer arithmetic on unsigned and signed interpretations.
   function automatic logic [W-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic m);
      int           ua, ub, sa, sb, tr;
      logic [N-1:0] s;
      logic         c, v;
      ua = int'(a);
      ub = int'(b);
      sa = a[N-1] ? ua - (1 << N) : ua;
      sb = b[N-1] ? ub - (1 << N) : ub;
      if (m) begin
         c  = (ua >= ub);
         tr = sa - sb;
         s  = N'(ua - ub);
      end else begin
         c  = ((ua + ub) >= (1 << N));
         tr = sa + sb;
         s  = N'(ua + ub);
      end
      v = (tr > (1 << (N - 1)) - 1) || (tr < -(1 << (N - 1)));
`ifdef ADDSUB_SAT_EN
      if (v) s = (tr > 0) ? {1'b0, {(N-1){1'b1}}} : {1'b1, {(N-1){1'b0}}};
`endif
      return {s, c, v, (s == '0)};
   endfunction

   task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic m,
                           input logic [W-1:0] e);
      @(negedge clk);
      bus.A     = a;
      bus.B     = b;
      bus.M     = m;
      bus.start = 1'b1;
      exp_q.push_back(e);
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   // lat0 = cycles already elapsed since the accepting edge; post = check the idle cycle after done.
   task automatic wait_done(input int lat0, input bit post);
      int           lat;
      int           busy_bad;
      int           hold_bad;
      bit           seen;
      logic [W-1:0] e;
      lat = lat0; busy_bad = 0; hold_bad = 0; seen = 0;
      while (!seen && lat < lat0 + 20) begin
         @(negedge clk);
         lat++;
         if (bus.done === 1'b1) seen = 1;
         else begin
            if (bus.busy !== 1'b1) busy_bad++;
            if (bus.S !== last_s) hold_bad++;
         end
      end
      if (!seen) begin
         n_tests++;
         n_fail++;
         $display("FAIL done_timeout: no done within %0d cycles at %0t", lat, $time);
         return;
      end
      if (exp_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard: done with empty expected queue at %0t", $time);
         return;
      end
      e = exp_q.pop_front();
      check("latency", lat, K + 1);
      check("S", bus.S, e[W-1:3]);
      check("Cout", bus.Cout, e[2]);
      check("V", bus.V, e[1]);
      check("Z", bus.Z, e[0]);
      check("busy_in_done", bus.busy, 1);
      check("busy_during_run", busy_bad, 0);
      check("S_hold", hold_bad, 0);
      last_s = e[W-1:3];
      if (post) begin
         @(negedge clk);
         check("done_single_pulse", bus.done, 0);
         check("busy_after_done", bus.busy, 0);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] a, b;
      logic         m;
      logic [W-1:0] first;
      int           done_cnt;

      // Vector table: a, b, m, expected S, Cout, V, Z.
      tbl[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{8'h10, 8'h10, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
      tbl[2] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
`ifdef ADDSUB_SAT_EN
      tbl[3] = '{8'h7F, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{8'h80, 8'h01, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0};
      tbl[6] = '{8'h80, 8'h80, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
`else
      tbl[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
      tbl[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
`endif

      // Reset held two cycles with start asserted.
      rst_n     = 1'b0;
      bus.start = 1'b1;
      bus.M     = 1'b0;
      bus.A     = 8'h5A;
      bus.B     = 8'h33;
      last_s    = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_S", bus.S, 0);
      check("rst_Cout", bus.Cout, 0);
      check("rst_V", bus.V, 0);
      check("rst_Z", bus.Z, 0);
      rst_n     = 1'b1;
      bus.start = 1'b0;
      @(negedge clk);
      check("rst_no_start", bus.busy, 0);

      for (int i = 0; i < 7; i++) begin
         start_op(tbl[i].a, tbl[i].b, tbl[i].m,
                  {tbl[i].s, tbl[i].cout, tbl[i].v, tbl[i].z});
         wait_done(0, 1'b1);
      end

      // start pulsed in cycle t+2 with new operands; A/B/M also changed mid-run.
      start_op(8'h21, 8'h13, 1'b0, {8'h34, 1'b0, 1'b0, 1'b0});
      @(negedge clk);
      @(negedge clk);
      bus.A     = 8'hC4;
      bus.B     = 8'h9E;
      bus.M     = 1'b1;
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      wait_done(2, 1'b1);

      // Back-to-back: start held from the DONE cycle, accepted at the first IDLE edge.
      first = model(8'h64, 8'h1C, 1'b1);
      start_op(8'h64, 8'h1C, 1'b1, first);
      wait_done(0, 1'b0);
      bus.A     = 8'h0F;
      bus.B     = 8'hF1;
      bus.M     = 1'b0;
      bus.start = 1'b1;
      exp_q.push_back(model(8'h0F, 8'hF1, 1'b0));
      @(negedge clk);
      check("b2b_idle_gap", bus.busy, 0);
      check("b2b_S_hold", bus.S, first[W-1:3]);
      @(posedge clk);
      #1 bus.start = 1'b0;
      wait_done(0, 1'b1);

      // Abort: reset sampled at edge t+3 mid-run; done must never appear.
      start_op(8'h12, 8'h34, 1'b0, model(8'h12, 8'h34, 1'b0));
      repeat (2) @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_busy", bus.busy, 0);
      check("abort_done", bus.done, 0);
      check("abort_S", bus.S, 0);
      check("abort_flags", {bus.Cout, bus.V, bus.Z}, 0);
      rst_n = 1'b1;
      exp_q.delete();
      last_s   = '0;
      done_cnt = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.done !== 1'b0) done_cnt++;
      end
      check("abort_no_done", done_cnt, 0);

      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         a = N'($urandom);
         b = N'($urandom);
         m = 1'($urandom_range(0, 1));
         start_op(a, b, m, model(a, b, m));
         wait_done(0, 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
